// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared types for the instruction-ROM fetch arbiter: FSM states, access owner, ROM read latency.
package rom_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_DBG = 1'b1
   } owner_e;

   // Block-RAM read data appears this many cycles after rom_en.
   localparam int ROM_LAT = 1;

endpackage

// File: rtl/rom_fetch_arbiter_if.sv
// Request/response and ROM-side signals of the fetch arbiter; slave = arbiter, master = requesters + ROM.
interface rom_fetch_arbiter_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic              if_err;
   logic [DATA_W-1:0] if_rdata;

   logic              dbg_req;
   logic [ADDR_W-1:0] dbg_addr;
   logic              dbg_gnt;
   logic              dbg_rvalid;
   logic              dbg_err;
   logic [DATA_W-1:0] dbg_rdata;

   logic              rom_en;
   logic [ADDR_W-3:0] rom_addr;
   logic [DATA_W-1:0] rom_data;

   modport slave (
      input  if_req, if_addr, dbg_req, dbg_addr, rom_data,
      output if_gnt, if_rvalid, if_err, if_rdata,
      output dbg_gnt, dbg_rvalid, dbg_err, dbg_rdata,
      output rom_en, rom_addr
   );

   modport master (
      output if_req, if_addr, dbg_req, dbg_addr, rom_data,
      input  if_gnt, if_rvalid, if_err, if_rdata,
      input  dbg_gnt, dbg_rvalid, dbg_err, dbg_rdata,
      input  rom_en, rom_addr
   );
endinterface

// File: rtl/rom_fetch_arbiter.sv
// Single-ported ROM arbiter: grant+rom_en in cycle N, rvalid in N+2, one access per 3 cycles; requests wait until granted.
// DBG port and its starvation counter exist only when ROM_ARB_DEBUG_EN is defined; otherwise DBG outputs are tied 0.
module rom_fetch_arbiter
   import rom_arb_pkg::*;
#(
   parameter int ADDR_W   = 17,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input logic                clock,
   input logic                reset_n,
   rom_fetch_arbiter_if.slave bus
);

   state_e            state_q, state_d;
   owner_e            owner_q;
   logic              err_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] cap_word;

   logic              issue;
   logic              any_req;
   logic              dbg_win;
   logic              if_gnt_w;
   logic              dbg_gnt_w;
   logic [ADDR_W-1:0] win_addr;
   logic              misaligned;

   assign issue = (state_q == ISSUE);

`ifdef ROM_ARB_DEBUG_EN
   logic [3:0]        dbg_wait_q;
   logic [DATA_W-1:0] dbg_rdata_q;

   assign any_req = bus.if_req | bus.dbg_req;
   assign dbg_win = bus.dbg_req & (~bus.if_req | (dbg_wait_q == 4'(MAX_WAIT)));

   // Counts IF grants that jumped a pending DBG request; saturation forces a DBG win.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dbg_wait_q <= '0;
      end else if (!bus.dbg_req || dbg_gnt_w) begin
         dbg_wait_q <= '0;
      end else if (if_gnt_w && (dbg_wait_q != 4'(MAX_WAIT))) begin
         dbg_wait_q <= dbg_wait_q + 4'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dbg_rdata_q <= '0;
      end else if ((state_q == WAIT) && (owner_q == OWN_DBG)) begin
         dbg_rdata_q <= cap_word;
      end
   end

   assign dbg_gnt_w      = issue & dbg_win;
   assign bus.dbg_gnt    = dbg_gnt_w;
   assign bus.dbg_rvalid = (state_q == RESP) && (owner_q == OWN_DBG);
   assign bus.dbg_err    = bus.dbg_rvalid & err_q;
   assign bus.dbg_rdata  = dbg_rdata_q;
`else
   logic unused_dbg;

   assign any_req        = bus.if_req;
   assign dbg_win        = 1'b0;
   assign dbg_gnt_w      = 1'b0;
   assign unused_dbg     = ^{bus.dbg_req, bus.dbg_addr};
   assign bus.dbg_gnt    = 1'b0;
   assign bus.dbg_rvalid = 1'b0;
   assign bus.dbg_err    = 1'b0;
   assign bus.dbg_rdata  = '0;
`endif

   assign win_addr   = dbg_win ? bus.dbg_addr : bus.if_addr;
   assign misaligned = |win_addr[1:0];
   assign if_gnt_w   = issue & bus.if_req & ~dbg_win;

   // Misaligned accesses are granted but never touch the ROM.
   assign bus.if_gnt   = if_gnt_w;
   assign bus.rom_en   = (if_gnt_w | dbg_gnt_w) & ~misaligned;
   assign bus.rom_addr = bus.rom_en ? win_addr[ADDR_W-1:2] : '0;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = any_req ? ISSUE : IDLE;
         ISSUE:   state_d = WAIT;
         WAIT:    state_d = RESP;
         RESP:    state_d = any_req ? ISSUE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         owner_q <= OWN_IF;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (issue) begin
            owner_q <= dbg_win ? OWN_DBG : OWN_IF;
            err_q   <= misaligned;
         end
      end
   end

   assign cap_word = err_q ? '0 : bus.rom_data;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         if_rdata_q <= '0;
      end else if ((state_q == WAIT) && (owner_q == OWN_IF)) begin
         if_rdata_q <= cap_word;
      end
   end

   assign bus.if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
   assign bus.if_err    = bus.if_rvalid & err_q;
   assign bus.if_rdata  = if_rdata_q;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Randomized bench for rom_fetch_arbiter against a transaction-level model; honours ROM_ARB_DEBUG_EN.
module tb_rom_fetch_arbiter;
   localparam int ADDR_W   = 17;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 4;
`ifdef ROM_ARB_DEBUG_EN
   localparam bit DBG_EN = 1'b1;
`else
   localparam bit DBG_EN = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   rom_fetch_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   rom_fetch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   function automatic logic [31:0] rom_word(input logic [14:0] w);
      return {~w[7:0], 1'b1, w, w[7:0]};
   endfunction

   // Synchronous-read ROM
   always @(posedge clock)
      if (bus.rom_en) bus.rom_data <= rom_word(bus.rom_addr);

   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   bit rst_next = 1'b0;

   // stimulus: 0 off, 1 one shot, 2 continuous aligned, 3 random
   int if_mode = 0, dbg_mode = 0;
   logic [16:0] if_shot, dbg_shot;
   bit if_busy = 0, dbg_busy = 0;

   // model of the access sequence
   int avail = 1;
   bit prev_if = 0, prev_dbg = 0;
   int wcnt = 0;
   bit rp = 0, rp_dbg = 0, rp_err = 0;
   int rp_at = 0;
   logic [14:0] rp_word;
   logic [31:0] last_if_rd = '0, last_dbg_rd = '0;
   bit g_if_last = 0, g_dbg_last = 0;

   bit e_ig, e_dg, e_ir, e_dr, e_ie, e_de, e_en;
   logic [14:0] e_ra;

   int gq_own[$];
   int gq_cyc[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
   endtask

   function automatic logic [16:0] rand_addr();
      logic [16:0] a;
      a = 17'($urandom_range(0, 131071));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      return a;
   endfunction

   task automatic drive_port(input int mode, input logic [16:0] shot, inout bit busy,
                             output bit raised, output logic [16:0] a);
      raised = 1'b0;
      a = '0;
      if (!busy) begin
         case (mode)
            1: begin busy = 1; raised = 1; a = shot; end
            2: begin busy = 1; raised = 1; a = {$urandom_range(0, 32767), 2'b00}; end
            3: if ($urandom_range(0, 2) == 0) begin busy = 1; raised = 1; a = rand_addr(); end
            default: ;
         endcase
      end
   endtask

   task automatic step();
      bit raised, dreq, pdreq, dwin, mis;
      logic [16:0] a, waddr;
      logic [31:0] d;
      @(posedge clock);
      #1;
      cyc++;
      reset_n = rst_next;
      if (!reset_n) begin
         if_busy = 0; dbg_busy = 0;
         bus.if_req = 0; bus.dbg_req = 0;
      end else begin
         if (g_if_last) if_busy = 0;
         if (g_dbg_last) dbg_busy = 0;
         drive_port(if_mode, if_shot, if_busy, raised, a);
         if (raised) begin bus.if_addr = a; if (if_mode == 1) if_mode = 0; end
         drive_port(dbg_mode, dbg_shot, dbg_busy, raised, a);
         if (raised) begin bus.dbg_addr = a; if (dbg_mode == 1) dbg_mode = 0; end
         bus.if_req = if_busy;
         bus.dbg_req = dbg_busy;
      end

      {e_ig, e_dg, e_ir, e_dr, e_ie, e_de, e_en} = '0;
      e_ra = '0;
      g_if_last = 0; g_dbg_last = 0;
      if (!reset_n) begin
         rp = 0; wcnt = 0; last_if_rd = '0; last_dbg_rd = '0;
         prev_if = 0; prev_dbg = 0;
         avail = cyc + 1;
      end else begin
         dreq  = DBG_EN && bus.dbg_req;
         pdreq = DBG_EN && prev_dbg;
         // A request seen once the arbiter is free is granted on the following cycle.
         if ((prev_if || pdreq) && (cyc - 1 >= avail)) begin
            dwin  = dreq && (!bus.if_req || wcnt == MAX_WAIT);
            waddr = dwin ? bus.dbg_addr : bus.if_addr;
            mis   = (waddr[1:0] != 2'b00);
            e_ig = !dwin; e_dg = dwin; e_en = !mis;
            e_ra = mis ? 15'd0 : waddr[16:2];
            rp = 1; rp_at = cyc + 2; rp_dbg = dwin; rp_err = mis; rp_word = waddr[16:2];
            avail = cyc + 2;
            g_if_last = !dwin; g_dbg_last = dwin;
         end
         if (rp && rp_at == cyc) begin
            d = rp_err ? 32'd0 : rom_word(rp_word);
            if (rp_dbg) begin e_dr = 1; e_de = rp_err; last_dbg_rd = d; end
            else begin e_ir = 1; e_ie = rp_err; last_if_rd = d; end
            rp = 0;
         end
         if (!dreq || g_dbg_last) wcnt = 0;
         else if (g_if_last && wcnt < MAX_WAIT) wcnt++;
         prev_if = bus.if_req; prev_dbg = bus.dbg_req;
      end

      @(negedge clock);
      chk("if_gnt", 32'(bus.if_gnt), 32'(e_ig));
      chk("dbg_gnt", 32'(bus.dbg_gnt), 32'(e_dg));
      chk("if_rvalid", 32'(bus.if_rvalid), 32'(e_ir));
      chk("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(e_dr));
      chk("if_err", 32'(bus.if_err), 32'(e_ie));
      chk("dbg_err", 32'(bus.dbg_err), 32'(e_de));
      chk("if_rdata", bus.if_rdata, last_if_rd);
      chk("dbg_rdata", bus.dbg_rdata, last_dbg_rd);
      chk("rom_en", 32'(bus.rom_en), 32'(e_en));
      chk("rom_addr", 32'(bus.rom_addr), 32'(e_ra));
      if (bus.if_gnt)  begin gq_own.push_back(0); gq_cyc.push_back(cyc); end
      if (bus.dbg_gnt) begin gq_own.push_back(1); gq_cyc.push_back(cyc); end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int bad_gap, n_if, n_dbg, rst_left;
      bus.if_req = 0; bus.dbg_req = 0; bus.if_addr = '0; bus.dbg_addr = '0;

      rst_next = 0;
      steps(3);
      chk("reset_rom_en", 32'(bus.rom_en), 32'd0);
      chk("reset_if_rdata", bus.if_rdata, 32'd0);
      rst_next = 1;
      step();

      // aligned IF fetch of byte address 0x10
      if_mode = 1; if_shot = 17'h00010;
      step();
      step();
      chk("lit_gnt", 32'(bus.if_gnt), 32'd1);
      chk("lit_rom_addr", 32'(bus.rom_addr), 32'h0004);
      steps(2);
      chk("lit_rvalid", 32'(bus.if_rvalid), 32'd1);
      chk("lit_rdata", bus.if_rdata, 32'hFB800404);

      // misaligned fetch
      if_mode = 1; if_shot = 17'h00013;
      steps(2);
      chk("lit_mis_rom_en", 32'(bus.rom_en), 32'd0);
      steps(2);
      chk("lit_mis_err", 32'(bus.if_err), 32'd1);
      chk("lit_mis_rdata", bus.if_rdata, 32'd0);

      // reset pulsed while the ROM read is in flight
      if_mode = 1; if_shot = 17'h00020;
      steps(2);
      rst_next = 0;
      steps(2);
      rst_next = 1;
      steps(4);
      chk("lit_post_rst_rdata", bus.if_rdata, 32'd0);
      if_mode = 1; if_shot = 17'h00010;
      steps(4);
      chk("lit_post_rst_resp", bus.if_rdata, 32'hFB800404);
      steps(2);

      // both ports requesting continuously
      gq_own.delete(); gq_cyc.delete();
      if_mode = 2; dbg_mode = 2;
      steps(30);
      if_mode = 0; dbg_mode = 0;
      bad_gap = 0; n_if = 0; n_dbg = 0;
      foreach (gq_own[i]) begin
         if (gq_own[i] == 0) n_if++; else n_dbg++;
         if (i > 0 && gq_cyc[i] - gq_cyc[i-1] != 3) bad_gap++;
      end
      chk("lit_grant_spacing", 32'(bad_gap), 32'd0);
      chk("lit_grant_total", 32'(n_if + n_dbg), 32'd10);
`ifdef ROM_ARB_DEBUG_EN
      chk("lit_if_grants", 32'(n_if), 32'd8);
      chk("lit_dbg_5th", 32'(gq_own[4]), 32'd1);
      chk("lit_if_4th", 32'(gq_own[3]), 32'd0);
      chk("lit_if_resume", 32'(gq_own[5]), 32'd0);
`else
      chk("lit_if_grants", 32'(n_if), 32'd10);
      chk("lit_no_dbg", 32'(n_dbg), 32'd0);
`endif
      steps(10);

      // alternating single requests
      for (int k = 0; k < 6; k++) begin
         if_mode = 1; if_shot = 17'({k[14:0], 2'b00});
         dbg_mode = 1; dbg_shot = 17'({15'(k + 100), 2'b00});
         steps(8);
      end

      // randomized traffic with occasional resets
      if_mode = 3; dbg_mode = 3;
      rst_left = 0;
      for (int i = 0; i < 3000; i++) begin
         if (rst_left > 0) rst_left--;
         else if ($urandom_range(0, 299) == 0) rst_left = 2;
         rst_next = (rst_left == 0);
         step();
      end
      rst_next = 1;
      if_mode = 0; dbg_mode = 0;
      steps(20);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/rom_fetch_arbiter.md
# rom_fetch_arbiter

Sequencer and arbiter for the multicycle processor's single-ported instruction ROM (32768 x 32-bit words, synchronous block-RAM read). It shares the ROM between the instruction-fetch unit (IF) and a debug/loader read port (DBG), issues at most one ROM access at a time and returns registered read data to the owning requester. IF has fixed priority. A wait counter bounds DBG starvation.

## Interface
Parameters:
- ADDR_W, 17, byte-address width; ROM word index is addr[ADDR_W-1:2]
- DATA_W, 32, instruction word width
- MAX_WAIT, 4, consecutive IF grants tolerated while DBG is pending (1..15)

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  IF read request; held with stable if_addr until if_gnt
- if_addr  in  ADDR_W  IF byte address
- if_gnt  out  1  one-cycle grant to IF
- if_rvalid  out  1  one-cycle response strobe to IF
- if_err  out  1  misaligned-address flag, qualified by if_rvalid
- if_rdata  out  DATA_W  IF response word
- dbg_req, dbg_addr, dbg_gnt, dbg_rvalid, dbg_err, dbg_rdata: same as IF, for DBG
- rom_en  out  1  ROM read enable
- rom_addr  out  ADDR_W-2  ROM word address
- rom_data  in  DATA_W  ROM data, valid one cycle after rom_en

## Operation
- FSM states and transitions:
  - IDLE -> ISSUE on any request
  - ISSUE -> WAIT
  - WAIT -> RESP
  - RESP -> ISSUE if a request is pending, else IDLE
- ISSUE (grant cycle), combinational outputs:
  - gnt for the winner
  - rom_en=1 and rom_addr=addr[ADDR_W-1:2], for aligned addresses only
  - owner and err are latched
- WAIT: rom_data is captured into the response register at the end of the cycle.
- RESP: owner's rvalid=1; rdata = the captured word, err = latched flag.
  - The other port's rvalid stays 0.
  - Its rdata holds its last value.
- Arbitration in ISSUE:
  - IF wins unless dbg_wait == MAX_WAIT.
  - dbg_wait (4-bit) increments on each IF grant while dbg_req=1.
  - dbg_wait clears on a DBG grant or when dbg_req=0.
  - dbg_wait saturates at MAX_WAIT.
- Misaligned address (addr[1:0] != 0):
  - still granted
  - rom_en stays 0
  - response delivered with err=1 and rdata=0 at normal latency
- Requests are not cancelled. Dropping req before gnt is a protocol violation, and the arbiter does not check it.
- At most one access is outstanding.

## Timing
- Grant in cycle N, rom_en in cycle N, rvalid in cycle N+2.
- Back-to-back throughput: one access per 3 cycles.
  - RESP and the next ISSUE do not overlap, so grants are spaced 3 cycles apart.
  - Sequence: ISSUE(N), WAIT(N+1), RESP(N+2), ISSUE(N+3).
- Simultaneous if_req and dbg_req with dbg_wait < MAX_WAIT: IF granted, dbg_wait+1.
- Reset values (asserted asynchronously):
  - state=IDLE
  - all gnt/rvalid/err/rom_en = 0
  - rdata = 0, rom_addr = 0, dbg_wait = 0
- Reset mid-access: any in-flight response is dropped. No rvalid follows reset release until a new grant.
- Outputs are valid after reset_n deassertion on the first rising edge; a request may be granted that cycle.

## Configuration
- ROM_ARB_DEBUG_EN defined: DBG port and starvation counter are built as above.
- Not defined:
  - dbg_gnt, dbg_rvalid and dbg_err are tied 0, and dbg_rdata is tied 0.
  - dbg_req and dbg_addr are ignored.
  - The counter is removed.
  - IF timing is unchanged.

## Structure
- Shared package rom_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP)
  - the owner enum (OWN_IF, OWN_DBG)
  - the ROM latency constant (1)
- No sub-module; the FSM, arbiter and response register live in one module.
- The ROM itself is instantiated by the parent, not inside this block.

## Test plan
- Single IF request, if_addr=0x00010 -> if_gnt at N, rom_en with rom_addr=0x0004, if_rvalid at N+2 with if_rdata=ROM[4], if_err=0.
- IF held continuously with DBG also requesting, MAX_WAIT=4 -> 4 IF grants, then dbg_gnt on the 5th ISSUE, then dbg_wait=0 and the IF grant resumes.
- Misaligned if_addr=0x00013 -> rom_en stays 0, if_rvalid at N+2 with if_err=1, if_rdata=0.
- reset_n pulsed low during WAIT -> no if_rvalid afterwards, all outputs 0, FSM in IDLE; next request served normally.
- Build without ROM_ARB_DEBUG_EN, dbg_req=1 permanently -> dbg_gnt/dbg_rvalid never assert; IF grants every 3 cycles.
- Both requesters alternating single requests -> each response goes only to its owner with the correct word; no rvalid cross-talk.
